// File: rtl/pci_master_ctrl.sv
// PCI initiator: turns one local request into an address phase, optional read turnaround and N data phases.
// Latency: ADDR the cycle after accept; each data phase completes on the first edge with IRDY and TRDY both low.
// Backpressure: req_ready only in IDLE; TRDY high stretches a data phase; unclaimed cycles master-abort.
module pci_master_ctrl #(
  parameter int unsigned LEN_W          = 4,
  parameter int unsigned DEVSEL_TIMEOUT = 4,
  parameter logic [3:0]  BYTE_EN        = 4'b0000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cmd,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [31:0]      wr_data,
  output logic             wr_pop,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             err,
  output logic             busy,
  inout  wire  [31:0]      AD,
  output logic [3:0]       CBE,
  output logic             FRAME,
  output logic             IRDY,
  input  logic             TRDY,
  input  logic             DEVSEL
);

  localparam int unsigned TW = $clog2(DEVSEL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_TURN, S_DATA, S_ABORT, S_DONE
  } state_t;

  state_t           state, state_n;
  logic [3:0]       cmd_q;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] remaining;
  logic [TW-1:0]    timer;
  logic             claimed;
  logic             aborted;
  logic             ad_oe;
  logic [31:0]      ad_out;
  logic             xfer;
  logic             timeout;
  logic             in_wait_window;

  assign AD = ad_oe ? ad_out : 32'bz;

  // A DEVSEL seen on this very edge counts as a claim, so the first data phase can complete immediately.
  assign in_wait_window = (state == S_TURN) || (state == S_DATA);
  assign xfer    = (state == S_DATA) && (claimed || !DEVSEL) && !TRDY;
  assign timeout = in_wait_window && !claimed && DEVSEL &&
                   (timer == TW'(DEVSEL_TIMEOUT - 1));

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = (state == S_DONE) && aborted;

  // State register; reset forces the bus idle immediately, even mid-burst.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state and bus drive; defaults are the idle bus.
  always_comb begin
    state_n = state;
    FRAME   = 1'b1;
    IRDY    = 1'b1;
    CBE     = 4'hF;
    ad_oe   = 1'b0;
    ad_out  = addr_q;
    case (state)
      S_IDLE: begin
        if (req_valid) state_n = S_ADDR;
      end
      S_ADDR: begin
        FRAME   = 1'b0;
        CBE     = cmd_q;
        ad_oe   = 1'b1;
        ad_out  = addr_q;
        state_n = cmd_q[0] ? S_DATA : S_TURN;
      end
      S_TURN: begin
        FRAME   = 1'b0;
        CBE     = BYTE_EN;
        state_n = timeout ? S_ABORT : S_DATA;
      end
      S_DATA: begin
        IRDY   = 1'b0;
        CBE    = BYTE_EN;
        // FRAME rises for the last phase only; remaining never reaches 0 while here.
        FRAME  = !(remaining > LEN_W'(1));
        ad_oe  = cmd_q[0];
        ad_out = wr_data;
        if (timeout)                               state_n = S_ABORT;
        else if (xfer && remaining == LEN_W'(1))   state_n = S_DONE;
      end
      S_ABORT: begin
        IRDY    = 1'b0;
        CBE     = BYTE_EN;
        state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Request latch, phase counter, DEVSEL timer and the per-phase write pop / read capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cmd_q     <= '0;
      addr_q    <= '0;
      remaining <= '0;
      timer     <= '0;
      claimed   <= 1'b0;
      aborted   <= 1'b0;
      wr_pop    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      wr_pop   <= 1'b0;
      rd_valid <= 1'b0;
      if (state == S_IDLE && req_valid) begin
        cmd_q     <= req_cmd;
        addr_q    <= req_addr;
        remaining <= (req_len == '0) ? LEN_W'(1) : req_len;
      end
      if (state == S_ADDR) begin
        timer   <= '0;
        claimed <= 1'b0;
        aborted <= 1'b0;
      end
      if (in_wait_window) begin
        if (!DEVSEL)       claimed <= 1'b1;
        else if (!claimed) timer   <= timer + 1'b1;
      end
      if (xfer) begin
        remaining <= remaining - 1'b1;
        if (cmd_q[0]) begin
          wr_pop <= 1'b1;
        end else begin
          rd_data  <= AD;
          rd_valid <= 1'b1;
        end
      end
      if (state == S_ABORT) aborted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pci_master_ctrl.sv
// Bench for pci_master_ctrl: behavioural PCI target, show-ahead write source and data scoreboard.
// A pull-up on AD makes a released bus read as all ones.
// Table of transactions plus hand sequences for turnaround, waits, abort, async reset and back-to-back.
module tb_pci_master_ctrl;
  localparam int LEN_W = 4;
  localparam logic [31:0] ZBUS = 32'hFFFF_FFFF;

  logic             CLK = 1'b0;
  logic             RST;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_cmd;
  logic [31:0]      req_addr;
  logic [LEN_W-1:0] req_len;
  logic [31:0]      wr_data;
  logic             wr_pop;
  logic [31:0]      rd_data;
  logic             rd_valid, done, err, busy;
  tri1  [31:0]      AD;
  logic [3:0]       CBE;
  logic             FRAME, IRDY;
  logic             TRDY = 1'b1;
  logic             DEVSEL = 1'b1;

  pci_master_ctrl #(.LEN_W(LEN_W), .DEVSEL_TIMEOUT(4), .BYTE_EN(4'b0000)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data), .wr_pop(wr_pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err), .busy(busy),
    .AD(AD), .CBE(CBE), .FRAME(FRAME), .IRDY(IRDY), .TRDY(TRDY), .DEVSEL(DEVSEL)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard of expected data words, in order.
  typedef struct {
    logic [31:0] dat;
    logic        last;
  } exp_t;
  exp_t q[$];
  exp_t me;

  // Show-ahead source: once wr_pop is seen the next word is already presented.
  logic [31:0] src [0:31];
  int          wcnt = 0;
  assign wr_data = src[(wcnt + (wr_pop ? 1 : 0)) % 32];

  // Target model configuration and state.
  bit          s_claim = 1'b1;
  int          s_wph = 0, s_wn = 0;
  bit          s_act = 1'b0, s_rd = 1'b0, s_drv = 1'b0;
  int          s_ph = 0, s_wait = 0;
  logic [31:0] s_dat = '0;
  logic        n_irdy = 1'b1, n_trdy = 1'b1, n_devsel = 1'b1, n_pop = 1'b0;
  assign AD = s_drv ? s_dat : 32'bz;

  bit cur_write = 1'b0;
  int n_busy = 0, n_pops = 0, n_rdv = 0;

  // Target: reacts just after each rising edge using pre-edge snapshots.
  always @(posedge CLK) begin
    #1;
    if (RST) begin
      s_act = 1'b0; s_drv = 1'b0; TRDY = 1'b1; DEVSEL = 1'b1;
    end else begin
      if (n_pop) wcnt++;
      if (!n_irdy && !n_trdy && !n_devsel) begin
        s_ph++;
        s_wait = (s_ph == s_wph) ? s_wn : 0;
      end
      if (!s_act && !FRAME && IRDY) begin
        s_act = 1'b1; s_rd = !CBE[0]; s_ph = 0;
        s_wait = (s_wph == 0) ? s_wn : 0;
        DEVSEL = 1'b1; TRDY = 1'b1;
      end else if (s_act && FRAME && IRDY) begin
        s_act = 1'b0; DEVSEL = 1'b1; TRDY = 1'b1;
      end else if (s_act) begin
        DEVSEL = !s_claim;
        if (!IRDY && s_claim) begin
          if (s_wait > 0) begin TRDY = 1'b1; s_wait--; end
          else TRDY = 1'b0;
        end else begin
          TRDY = 1'b1;
        end
      end
      s_drv = s_act && s_rd && s_claim && !IRDY;
      s_dat = src[s_ph % 32];
    end
  end

  // Monitor: snapshots, event counters, scoreboard pops.
  always @(negedge CLK) begin
    n_irdy = IRDY; n_trdy = TRDY; n_devsel = DEVSEL; n_pop = wr_pop;
    if (busy) n_busy++;
    if (wr_pop) n_pops++;
    if (rd_valid || (cur_write && !IRDY && !TRDY && !DEVSEL)) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_underflow: data phase with no expected word (t=%0t)", $time);
      end else begin
        me = q.pop_front();
        if (rd_valid) begin
          n_rdv++;
          chk("rd_data", rd_data, me.dat);
        end else begin
          chk("wr_ad", AD, me.dat);
          chk("wr_frame_last", {31'd0, FRAME}, {31'd0, me.last});
        end
      end
    end
  end

  // Issue one request from idle; returns at the ADDR cycle after checking it.
  task automatic start(input logic [3:0] cmd, input logic [31:0] addr, input logic [3:0] len,
                       input logic [31:0] base, input bit claim, input int wph, input int wn);
    int nb;
    nb = (len == 0) ? 1 : int'(len);
    for (int k = 0; k < 32; k++) src[k] = base + k;
    s_claim = claim; s_wph = wph; s_wn = wn; cur_write = cmd[0];
    wcnt = 0; n_busy = 0; n_pops = 0; n_rdv = 0;
    if (claim) for (int k = 0; k < nb; k++) q.push_back('{base + k, k == nb - 1});
    req_valid = 1'b1; req_cmd = cmd; req_addr = addr; req_len = len;
    @(negedge CLK);
    req_valid = 1'b0;
    chk("addr_ad", AD, addr);
    chk("addr_cbe", {28'd0, CBE}, {28'd0, cmd});
    chk("addr_frame_irdy", {30'd0, FRAME, IRDY}, 32'd1);
  endtask

  task automatic wait_done(output bit seen, output logic e);
    int cyc;
    cyc = 0; seen = 1'b0; e = 1'b0;
    while (cyc < 64 && !seen) begin
      if (done) begin seen = 1'b1; e = err; end
      else begin @(negedge CLK); cyc++; end
    end
  endtask

  task automatic finish(input bit exp_err, input int exp_busy, input int exp_beats);
    bit   seen;
    logic e;
    wait_done(seen, e);
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("err", {31'd0, e}, {31'd0, exp_err});
    @(negedge CLK);
    chk("busy_cycles", n_busy, exp_busy);
    chk("wr_pops", n_pops, cur_write ? exp_beats : 0);
    chk("rd_valids", n_rdv, cur_write ? 0 : exp_beats);
    chk("sb_drained", q.size(), 0);
    chk("idle_bus", {26'd0, FRAME, IRDY, CBE}, 32'h3F);
    chk("idle_ad", AD, ZBUS);
    chk("idle_ready_busy", {30'd0, req_ready, busy}, 32'd2);
  endtask

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [31:0] base;
    bit          claim;
    int          wph;
    int          wn;
    bit          exp_err;
    int          exp_busy;
    int          exp_beats;
  } vec_t;
  vec_t tv [8];

  initial begin
    bit   seen;
    logic e;
    // Busy cycles: ADDR + TURN(read) + phases + waits + DONE; abort is ADDR + 4 timer cycles + ABORT + DONE.
    tv[0] = '{4'h3, 32'h0000_0100, 4'd1,  32'h0000_00A0, 1'b1, 0, 0, 1'b0, 3,  1};
    tv[1] = '{4'h2, 32'h0000_0200, 4'd2,  32'h0000_00B0, 1'b1, 0, 1, 1'b0, 6,  2};
    tv[2] = '{4'h3, 32'h0000_0300, 4'd0,  32'h0000_00C0, 1'b1, 0, 0, 1'b0, 3,  1};
    tv[3] = '{4'h2, 32'h0000_0400, 4'd4,  32'hDEAD_0000, 1'b1, 0, 0, 1'b0, 7,  4};
    tv[4] = '{4'h3, 32'h0000_0500, 4'd15, 32'h5A00_0000, 1'b1, 7, 3, 1'b0, 20, 15};
    tv[5] = '{4'h2, 32'h0000_0600, 4'd2,  32'h0000_00D0, 1'b0, 0, 0, 1'b1, 7,  0};
    tv[6] = '{4'h3, 32'h0000_0700, 4'd3,  32'h0000_00E0, 1'b0, 0, 0, 1'b1, 7,  0};
    tv[7] = '{4'h3, 32'h0000_0800, 4'd2,  32'h0000_00F0, 1'b1, 0, 5, 1'b0, 9,  2};

    RST = 1'b1; req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_len = '0;
    for (int k = 0; k < 32; k++) src[k] = '0;
    @(negedge CLK);
    chk("rst_bus", {26'd0, FRAME, IRDY, CBE}, 32'h3F);
    chk("rst_ad", AD, ZBUS);
    chk("rst_flags", {26'd0, req_ready, wr_pop, rd_valid, done, err, busy}, 32'h20);
    chk("rst_rd_data", rd_data, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Single write: data phase carries the word with FRAME already high.
    start(4'h3, 32'h10, 4'd1, 32'hC9C5, 1'b1, 0, 0);
    @(negedge CLK);
    chk("w1_ad", AD, 32'hC9C5);
    chk("w1_frame_irdy", {30'd0, FRAME, IRDY}, 32'd2);
    finish(1'b0, 3, 1);

    // Single read: turnaround releases AD with IRDY high.
    start(4'h2, 32'h20, 4'd1, 32'h1234ABCD, 1'b1, 0, 0);
    @(negedge CLK);
    chk("turn_ad", AD, ZBUS);
    chk("turn_bus", {26'd0, FRAME, IRDY, CBE}, 32'h10);
    finish(1'b0, 4, 1);

    // Write burst 1/2/3 with two wait states ahead of the second phase.
    start(4'h3, 32'h30, 4'd3, 32'h1, 1'b1, 1, 2);
    @(negedge CLK);
    chk("burst_ad1", AD, 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("burst_ad2_hold", {AD[30:0], FRAME}, {31'h2, 1'b0});
    end
    @(negedge CLK);
    chk("burst_ad3_last", {AD[30:0], FRAME}, {31'h3, 1'b1});
    finish(1'b0, 7, 3);

    // No target claims: master abort after the DEVSEL window.
    start(4'h3, 32'h90, 4'd2, 32'h99, 1'b0, 0, 0);
    repeat (5) @(negedge CLK);
    chk("abort_frame_irdy", {30'd0, FRAME, IRDY}, 32'd2);
    chk("abort_ad", AD, ZBUS);
    finish(1'b1, 7, 0);

    for (int i = 0; i < 8; i++) begin
      start(tv[i].cmd, tv[i].addr, tv[i].len, tv[i].base, tv[i].claim, tv[i].wph, tv[i].wn);
      finish(tv[i].exp_err, tv[i].exp_busy, tv[i].exp_beats);
    end

    // Asynchronous reset during phase 2 of 4.
    start(4'h3, 32'hA0, 4'd4, 32'h50, 1'b1, 0, 0);
    repeat (2) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_frame_irdy", {30'd0, FRAME, IRDY}, 32'd3);
    chk("mid_rst_ad", AD, ZBUS);
    chk("mid_rst_busy_pop", {29'd0, busy, wr_pop, req_ready}, 32'd1);
    q.delete();
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    start(4'h2, 32'hB0, 4'd2, 32'h70, 1'b1, 0, 0);
    finish(1'b0, 5, 2);

    // Back-to-back with req_valid held: one idle cycle, then the second ADDR.
    for (int k = 0; k < 32; k++) src[k] = 32'hE0 + k;
    wcnt = 0; n_busy = 0; n_pops = 0; n_rdv = 0; cur_write = 1'b1;
    s_claim = 1'b1; s_wph = 0; s_wn = 0;
    q.push_back('{32'hE0, 1'b1});
    q.push_back('{32'hE1, 1'b1});
    req_valid = 1'b1; req_cmd = 4'h3; req_addr = 32'h40; req_len = 4'd1;
    @(negedge CLK);
    chk("b2b_ready_in_addr", {31'd0, req_ready}, 32'd0);
    wait_done(seen, e);
    chk("b2b_done1", {31'd0, seen}, 32'd1);
    @(negedge CLK);
    chk("b2b_gap_idle", {30'd0, busy, req_ready}, 32'd1);
    req_addr = 32'h44;
    @(negedge CLK);
    chk("b2b_addr2", {AD[30:0], FRAME}, {31'h44, 1'b0});
    req_valid = 1'b0;
    finish(1'b0, 6, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/pci_master_ctrl.md
Name: pci_master_ctrl

Overview:
- PCI initiator that sits directly upstream of PCI_Slave and drives the shared bus signals AD, CBE, FRAME and IRDY into it.
- Converts single requests from a local command interface into PCI read or write bursts: address phase, optional turnaround, then N data phases.
- Provides master-abort handling when no target claims the cycle.

Parameters:
- LEN_W, 4, width of the burst-length field (maximum burst is 2^LEN_W-1 data phases).
- DEVSEL_TIMEOUT, 4, number of cycles after the address phase to wait for DEVSEL before master abort.
- BYTE_EN, 4'b0000, active-low CBE value driven during data phases.

Ports:
- CLK  in  1  bus clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  1  local request present.
- req_ready  out  1  high only in IDLE; request accepted when req_valid and req_ready are both high.
- req_cmd  in  4  PCI command; bit0=0 is a read (e.g. 4'b0010), bit0=1 is a write (e.g. 4'b0011).
- req_addr  in  32  target address.
- req_len  in  LEN_W  number of data phases; 0 is treated as 1.
- wr_data  in  32  write data; must be valid while wr_pop is pending.
- wr_pop  out  1  one-cycle pulse when a write data phase completes; source advances to the next word.
- rd_data  out  32  captured read word.
- rd_valid  out  1  one-cycle pulse, one cycle after a read data phase completes; no backpressure.
- done  out  1  one-cycle pulse at the end of every transaction.
- err  out  1  one-cycle pulse, coincident with done, when the transaction was master-aborted.
- busy  out  1  high in every state except IDLE.
- AD  inout  32  multiplexed address/data; high-Z when not driven.
- CBE  out  4  command / byte enables.
- FRAME  out  1  active-low.
- IRDY  out  1  active-low.
- TRDY  in  1  active-low, driven by the slave.
- DEVSEL  in  1  active-low, driven by the slave.

Behaviour:
- Reset (asynchronous, immediate, also mid-burst):
  - FRAME=1, IRDY=1, CBE=4'hF, AD=Z.
  - req_ready=1; wr_pop, rd_valid, done, err, busy all 0; rd_data=0.
  - State=IDLE; all counters cleared.
- States: IDLE, ADDR, TURN, DATA, ABORT, DONE.
- IDLE:
  - Bus outputs as at reset.
  - On accept: latch cmd, addr, and len (0 becomes 1) into remaining; go to ADDR.
- ADDR (1 cycle):
  - FRAME=0, IRDY=1, AD=addr, CBE=cmd.
  - Next state is TURN for a read, DATA for a write.
  - Clear the DEVSEL timer and the claimed flag.
- TURN (read only, 1 cycle):
  - AD=Z, CBE=BYTE_EN, IRDY=1, FRAME=0.
  - Go to DATA.
- DATA:
  - IRDY=0, CBE=BYTE_EN.
  - AD=wr_data on a write; AD=Z on a read.
  - FRAME=0 while remaining>1; FRAME=1 in the final data phase (remaining==1).
  - A phase completes on the rising edge where IRDY==0 and TRDY==0.
  - On completion: decrement remaining.
    - Write: pulse wr_pop in the following cycle.
    - Read: register AD into rd_data and pulse rd_valid in the following cycle.
    - If remaining was 1, go to DONE.
  - TRDY==1 inserts a wait state: all outputs hold, AD keeps the same write word, no pop.
  - Wait states are unlimited once the target has claimed.
- DEVSEL timer:
  - Counts every cycle in TURN/DATA while DEVSEL==1 and claimed==0.
  - DEVSEL==0 on any edge sets claimed and freezes the timer.
  - Timer reaching DEVSEL_TIMEOUT with claimed==0 → ABORT (master abort).
  - Simultaneous TRDY==0 and timeout is impossible while unclaimed; TRDY is ignored until claimed.
- ABORT (1 cycle):
  - FRAME=1, IRDY=0, AD=Z.
  - Then DONE with err set.
  - Remaining data is discarded; no wr_pop or rd_valid.
- DONE (1 cycle):
  - FRAME=1, IRDY=1, AD=Z, CBE=4'hF.
  - Pulse done (and err if aborted); return to IDLE.
  - req_ready rises next cycle, so back-to-back transactions have at least 1 idle bus cycle between them.
- Ordering rules:
  - FRAME never returns to 0 after going to 1 within a transaction.
  - IRDY never goes to 1 while FRAME==0 in DATA.
- busy=1 from ADDR through DONE.

Test Plan:
- Write, len=1, cmd=4'b0011, addr=0x10, wr_data=0xC9C5, slave TRDY=0 and DEVSEL=0 on the first data edge:
  - ADDR shows AD=0x10, CBE=0011, FRAME=0.
  - Next cycle AD=0xC9C5, IRDY=0, FRAME=1.
  - wr_pop, then done with err=0; bus returns to idle.
- Read, len=1, cmd=4'b0010, slave returns 0x1234ABCD:
  - TURN cycle has AD=Z and IRDY=1.
  - rd_data=0x1234ABCD with rd_valid one cycle after completion; done pulses.
- Write burst, len=3, data 0x1/0x2/0x3, TRDY held 1 for 2 cycles before phase 2:
  - Three wr_pop pulses; AD holds 0x2 through the wait states.
  - FRAME=1 only during the phase carrying 0x3.
- DEVSEL held 1 forever, len=2:
  - After 4 cycles: ABORT (FRAME=1, IRDY=0), then DONE.
  - done=1 with err=1; no wr_pop or rd_valid.
- RST=1 mid-burst (during phase 2 of 4):
  - Same cycle: FRAME=1, IRDY=1, AD=Z, busy=0.
  - After release, a new request starts cleanly at ADDR.
- Two back-to-back requests, req_valid held high:
  - Second ADDR occurs exactly 1 cycle after the first DONE; req_ready=1 only in IDLE.
